// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-side pointer, full/almost-full, level and overflow control
// Runs wholly in the write clock domain against the already-synchronized Gray read pointer.
module fifo_wr_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int AFULL_THRESH = 28
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_rst,
  input  logic                  i_w_inc,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  input  logic [ADDR_WIDTH:0]   i_wq2_rptr,
  input  logic                  i_ovf_clr,
  output logic                  o_w_en,
  output logic [ADDR_WIDTH-1:0] o_w_addr,
  output logic [DATA_WIDTH-1:0] o_w_data,
  output logic [ADDR_WIDTH:0]   o_wptr,
  output logic                  o_w_full,
  output logic                  o_w_afull,
  output logic [ADDR_WIDTH:0]   o_w_level,
  output logic                  o_w_ovf,
  output logic [7:0]            o_w_drop_cnt
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [ADDR_WIDTH:0] wbin;
  logic [ADDR_WIDTH:0] wbin_next;
  logic [ADDR_WIDTH:0] wgray_next;
  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] level_next;
  logic                full_next;
  logic                afull_next;
  logic                reject;

  assign o_w_en     = i_w_inc & ~o_w_full;
  assign reject     = i_w_inc & o_w_full;
  assign o_w_addr   = wbin[ADDR_WIDTH-1:0];
  assign o_w_data   = i_w_data;

  assign wbin_next  = wbin + PW'(o_w_en);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(i_wq2_rptr >> i);
    end
  end

  assign level_next = wbin_next - rbin;
  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign full_next  = (wgray_next == {~i_wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                                       i_wq2_rptr[ADDR_WIDTH-2:0]});
  assign afull_next = (level_next >= AFULL_LVL);

  always_ff @(posedge i_w_clk) begin
    if (i_w_rst) begin
      wbin         <= '0;
      o_wptr       <= '0;
      o_w_full     <= 1'b0;
      o_w_afull    <= 1'b0;
      o_w_level    <= '0;
      o_w_ovf      <= 1'b0;
      o_w_drop_cnt <= 8'd0;
    end else begin
      wbin      <= wbin_next;
      o_wptr    <= wgray_next;
      o_w_full  <= full_next;
      o_w_afull <= afull_next;
      o_w_level <= level_next;
      // A rejection in the same cycle as a clear restarts the count at one.
      if (reject) begin
        o_w_ovf <= 1'b1;
        if (i_ovf_clr)
          o_w_drop_cnt <= 8'd1;
        else if (o_w_drop_cnt != 8'hFF)
          o_w_drop_cnt <= o_w_drop_cnt + 8'd1;
      end else if (i_ovf_clr) begin
        o_w_ovf      <= 1'b0;
        o_w_drop_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - self-checking bench for fifo_wr_ctrl
module tb_fifo_wr_ctrl;

  logic       i_w_clk = 1'b0;
  logic       i_w_rst;
  logic       i_w_inc;
  logic [7:0] i_w_data;
  logic [5:0] i_wq2_rptr;
  logic       i_ovf_clr;
  logic       o_w_en;
  logic [4:0] o_w_addr;
  logic [7:0] o_w_data;
  logic [5:0] o_wptr;
  logic       o_w_full;
  logic       o_w_afull;
  logic [5:0] o_w_level;
  logic       o_w_ovf;
  logic [7:0] o_w_drop_cnt;

  fifo_wr_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .AFULL_THRESH(28)) dut (
    .i_w_clk(i_w_clk), .i_w_rst(i_w_rst), .i_w_inc(i_w_inc), .i_w_data(i_w_data),
    .i_wq2_rptr(i_wq2_rptr), .i_ovf_clr(i_ovf_clr), .o_w_en(o_w_en), .o_w_addr(o_w_addr),
    .o_w_data(o_w_data), .o_wptr(o_wptr), .o_w_full(o_w_full), .o_w_afull(o_w_afull),
    .o_w_level(o_w_level), .o_w_ovf(o_w_ovf), .o_w_drop_cnt(o_w_drop_cnt)
  );

  always #5 i_w_clk = ~i_w_clk;

  typedef struct {
    bit rst; bit inc; bit clr; logic [5:0] rptr;
    bit chk_en; bit en; logic [5:0] wptr; logic [4:0] addr; logic [5:0] level;
    bit full; bit afull; bit ovf; logic [7:0] drop;
  } vec_t;
  vec_t tbl[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counts of accepted writes and of entries the read side has released.
  int m_wr = 0;
  int m_level = 0;
  int m_drop = 0;
  bit m_full = 0, m_afull = 0, m_ovf = 0;

  function automatic logic [5:0] gray6(input int n);
    logic [5:0] b;
    b = 6'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, inc, clr, input logic [5:0] rptr, input bit chk_en, en,
                     input logic [5:0] wptr, input logic [4:0] addr, input logic [5:0] level,
                     input bit full, afull, ovf, input logic [7:0] drop);
    vec_t v;
    v.rst = rst; v.inc = inc; v.clr = clr; v.rptr = rptr; v.chk_en = chk_en; v.en = en;
    v.wptr = wptr; v.addr = addr; v.level = level; v.full = full; v.afull = afull;
    v.ovf = ovf; v.drop = drop;
    tbl.push_back(v);
  endtask

  task automatic drive_edge(input bit rst, inc, clr, input logic [5:0] rptr,
                            output bit en_pre, output logic [4:0] addr_pre, output bit data_ok);
    i_w_rst = rst; i_w_inc = inc; i_ovf_clr = clr; i_wq2_rptr = rptr;
    i_w_data = 8'($urandom);
    #2;
    en_pre = o_w_en;
    addr_pre = o_w_addr;
    data_ok = (o_w_data == i_w_data);
    @(posedge i_w_clk);
    #1;
  endtask

  task automatic step(input bit rst, inc, clr, input int rd);
    bit en_pre, dok, acc, rej;
    logic [4:0] a_pre;
    drive_edge(rst, inc, clr, gray6(rd), en_pre, a_pre, dok);
    if (!rst) begin
      check("w_en", int'(en_pre), int'(inc & !m_full));
      check("w_addr_pre", int'(a_pre), m_wr % 32);
    end
    check("w_data", int'(dok), 1);
    if (rst) begin
      m_wr = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0; m_drop = 0;
    end else begin
      acc = inc & !m_full;
      rej = inc & m_full;
      m_wr += int'(acc);
      m_level = m_wr - rd;
      m_full = (m_level == 32);
      m_afull = (m_level >= 28);
      if (rej) begin
        m_ovf = 1;
        m_drop = clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
      end else if (clr) begin
        m_ovf = 0;
        m_drop = 0;
      end
    end
    check("wptr", int'(o_wptr), int'(gray6(m_wr)));
    check("addr", int'(o_w_addr), m_wr % 32);
    check("level", int'(o_w_level), m_level);
    check("full", int'(o_w_full), int'(m_full));
    check("afull", int'(o_w_afull), int'(m_afull));
    check("ovf", int'(o_w_ovf), int'(m_ovf));
    check("drop", int'(o_w_drop_cnt), m_drop);
  endtask

  initial begin
    bit en_pre, dok, wrap_seen;
    logic [4:0] a_pre, prev_addr;
    logic [5:0] prev_wptr;
    int rd, q1, q2;
    bit r_rst, r_inc, r_clr;

    // Directed table: reset, fill to full, overflow, clear race, release, refill.
    add(1, 1, 0, 6'h00, 0, 0, 6'h00, 5'd0, 6'd0, 0, 0, 0, 8'd0);
    add(1, 1, 0, 6'h00, 0, 0, 6'h00, 5'd0, 6'd0, 0, 0, 0, 8'd0);
    for (int i = 1; i <= 32; i++)
      add(0, 1, 0, 6'h00, 1, 1, gray6(i), 5'(i), 6'(i), i == 32, i >= 28, 0, 8'd0);
    for (int d = 1; d <= 3; d++)
      add(0, 1, 0, 6'h00, 1, 0, 6'h30, 5'd0, 6'd32, 1, 1, 1, 8'(d));
    add(0, 1, 1, 6'h00, 1, 0, 6'h30, 5'd0, 6'd32, 1, 1, 1, 8'd1);
    add(0, 0, 0, 6'h01, 1, 0, 6'h30, 5'd0, 6'd31, 0, 1, 1, 8'd1);
    add(0, 1, 0, 6'h01, 1, 1, 6'h31, 5'd1, 6'd32, 1, 1, 1, 8'd1);
    add(0, 1, 0, 6'h01, 1, 0, 6'h31, 5'd1, 6'd32, 1, 1, 1, 8'd2);
    add(0, 0, 1, 6'h01, 1, 0, 6'h31, 5'd1, 6'd32, 1, 1, 0, 8'd0);

    foreach (tbl[k]) begin
      drive_edge(tbl[k].rst, tbl[k].inc, tbl[k].clr, tbl[k].rptr, en_pre, a_pre, dok);
      if (tbl[k].chk_en) check($sformatf("tbl%0d_en", k), int'(en_pre), int'(tbl[k].en));
      check($sformatf("tbl%0d_wptr", k), int'(o_wptr), int'(tbl[k].wptr));
      check($sformatf("tbl%0d_addr", k), int'(o_w_addr), int'(tbl[k].addr));
      check($sformatf("tbl%0d_level", k), int'(o_w_level), int'(tbl[k].level));
      check($sformatf("tbl%0d_full", k), int'(o_w_full), int'(tbl[k].full));
      check($sformatf("tbl%0d_afull", k), int'(o_w_afull), int'(tbl[k].afull));
      check($sformatf("tbl%0d_ovf", k), int'(o_w_ovf), int'(tbl[k].ovf));
      check($sformatf("tbl%0d_drop", k), int'(o_w_drop_cnt), int'(tbl[k].drop));
    end

    // Reset in the middle of a fill at level 17.
    step(1, 1, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0);
    check("mid_level_before", int'(o_w_level), 17);
    step(1, 1, 0, 0);
    check("mid_rst_wptr", int'(o_wptr), 0);
    check("mid_rst_level", int'(o_w_level), 0);
    step(0, 1, 0, 0);
    check("mid_first_addr_next", int'(o_w_addr), 1);

    // Drop counter saturation under a long run of rejected writes.
    step(1, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 260; i++) step(0, 1, 0, 0);
    check("drop_saturated", int'(o_w_drop_cnt), 255);

    // Wrap-around with the read pointer trailing through a two-flop synchronizer.
    step(1, 0, 0, 0);
    q1 = 0; q2 = 0; wrap_seen = 0;
    prev_wptr = o_wptr;
    for (int c = 0; c < 100; c++) begin
      prev_addr = o_w_addr;
      step(0, 1, 0, q2);
      check("wrap_gray_1bit", $countones(o_wptr ^ prev_wptr), 1);
      check("wrap_no_full", int'(o_w_full), 0);
      if (c >= 4) check("wrap_level_4_5", int'(o_w_level >= 6'd4 && o_w_level <= 6'd5), 1);
      if (prev_addr == 5'd31 && o_w_addr == 5'd0) wrap_seen = 1;
      q2 = q1;
      q1 = (m_wr > 2) ? m_wr - 2 : 0;
      prev_wptr = o_wptr;
    end
    check("wrap_addr_31_to_0", int'(wrap_seen), 1);

    // Randomized traffic against the reference model.
    step(1, 0, 0, 0);
    rd = 0;
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 399) == 0);
      if (r_rst) rd = 0;
      else if ($urandom_range(0, 99) < 40 && rd < m_wr) rd++;
      r_inc = ($urandom_range(0, 99) < 65);
      r_clr = ($urandom_range(0, 24) == 0);
      step(r_rst, r_inc, r_clr, rd);
      if (r_rst) rd = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
